axis_pfb_qout_v2: RTL and testbench
===================================

AXIS_PFB_QOUT_V2 -- requirements
Module: axis_pfb_qout_v2

Interface
REQ-001 Parameter N, default 16: number of PFB channels per beat.
REQ-002 Parameter BIN, default 24: input width per I or Q component (two's complement).
REQ-003 Parameter BOUT, default 16: output width per I or Q component; BOUT < BIN.
REQ-004 Parameter FRAME, default 8: output beats per frame (tlast period), FRAME >= 1.
REQ-005 Port aclk, in, 1: single clock for all ports.
REQ-006 Port aresetn, in, 1: reset, asynchronous, active-low.
REQ-007 Port s_axis_tvalid, in, 1: input beat valid.
REQ-008 Port s_axis_tready, out, 1: input beat accepted when high with tvalid.
REQ-009 Port s_axis_tdata, in, N*2*BIN: channel k at [k*2*BIN +: 2*BIN]; I in low BIN bits, Q in high BIN bits.
REQ-010 Port m_axis_tvalid, out, 1: output beat valid.
REQ-011 Port m_axis_tready, in, 1: downstream ready (backpressure; absent in v1).
REQ-012 Port m_axis_tdata, out, N*2*BOUT: channel k at [k*2*BOUT +: 2*BOUT]; I low, Q high.
REQ-013 Port m_axis_tlast, out, 1: high on last beat of each FRAME-beat frame.
REQ-014 Port qout, in, 8: quantization shift (QOUT_REG[7:0] from the register block).
REQ-015 Port ovf_clr, in, 1: single-cycle clear of sticky overflow flags.
REQ-016 Port ovf, out, N: per-channel sticky saturation flag.

Function
REQ-017 Two pipeline stages: S1 (round) and S2 (saturate, output register); m_axis_* driven directly from S2 registers.
REQ-018 Handshakes: adv2 = !v2 | m_axis_tready; adv1 = !v1 | adv2; s_axis_tready = adv1 (combinational path from m_axis_tready permitted).
REQ-019 Latency: beat accepted at cycle t appears on m_axis at t+2 when m_axis_tready is held high; full throughput of one beat per cycle.
REQ-020 Under backpressure, at most 2 beats held; no beat dropped, duplicated or reordered; m_axis_tdata/tlast stable while tvalid & !tready.
REQ-021 Effective shift q = min(qout, BIN-BOUT); sampled per beat at S1 acceptance; qout changes never affect beats already accepted.
REQ-022 Per component: r = (x + (q>0 ? 2^(q-1) : 0)) >>> q, computed in BIN+1 bits (round half up, arithmetic shift).
REQ-023 Saturation: r > 2^(BOUT-1)-1 -> 2^(BOUT-1)-1; r < -2^(BOUT-1) -> -2^(BOUT-1); otherwise r[BOUT-1:0].
REQ-024 ovf[k] sets in the cycle a beat carrying a saturated I or Q of channel k is loaded into S2; stays set until ovf_clr.
REQ-025 ovf_clr and a new saturation event for channel k in the same cycle: ovf[k] remains 1 (set wins); other bits clear.
REQ-026 Beat counter 0..FRAME-1 increments on each output transfer (m_axis_tvalid & m_axis_tready), wraps to 0 after FRAME-1; m_axis_tlast = v2 & (count == FRAME-1).
REQ-027 FRAME = 1: m_axis_tlast high on every valid beat.
REQ-028 Simultaneous S2 output transfer and S2 load: new beat replaces old with no bubble cycle.

Reset
REQ-029 While aresetn is low: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, ovf=0, beat counter=0, v1=v2=0, s_axis_tready=1.
REQ-030 Reset asserted mid-operation discards in-flight beats immediately (asynchronous); first beat after release starts a new frame at count 0.

Verification
REQ-031 N=16,BIN=24,BOUT=16, qout=8, ch0 I=0x123480, Q=0x000040, tready=1 -> ch0 I=0x1235, Q=0x0000 at t+2, ovf=0.
REQ-032 qout=0, ch3 I=0x010000, Q=0xFF0000 -> ch3 I=0x7FFF, Q=0x8000, ovf[3]=1; pulse ovf_clr with no further saturation -> ovf=0.
REQ-033 qout=8, I=0x7FFF80 (rounds to 0x8000) -> 0x7FFF, ovf set; qout=20 behaves identically to qout=8.
REQ-034 Continuous input, m_axis_tready low 5 cycles -> exactly 2 beats accepted then s_axis_tready=0; on release, all beats emerge in order, none lost.
REQ-035 FRAME=4, send 9 beats with random tready stalls -> m_axis_tlast on output beats 4 and 8 only, stable during stalls.
REQ-036 aresetn low for 1 cycle while 2 beats in flight -> m_axis_tvalid=0 and ovf=0 immediately; next beats counted from frame position 0.

Source files
------------

// File: rtl/axis_pfb_qout_v2.sv
// Requantizes N complex PFB channels from BIN to BOUT bits per component.
// Two-stage AXI-Stream pipeline: round, then saturate into the output register.
module axis_pfb_qout_v2 #(
    parameter int N     = 16,
    parameter int BIN   = 24,
    parameter int BOUT  = 16,
    parameter int FRAME = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [N*2*BIN-1:0]     s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [N*2*BOUT-1:0]    m_axis_tdata,
    output logic                   m_axis_tlast,
    input  logic [7:0]             qout,
    input  logic                   ovf_clr,
    output logic [N-1:0]           ovf
);

    localparam int QMAX = BIN - BOUT;
    localparam int RW   = BIN + 1;
    localparam int CW   = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic signed [RW-1:0] MAXV = {{(RW-BOUT+1){1'b0}}, {(BOUT-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-BOUT+1){1'b1}}, {(BOUT-1){1'b0}}};

    // Round half up by adding half an LSB of the shifted result, then shift arithmetically.
    function automatic logic signed [RW-1:0] round_comp(input logic signed [BIN-1:0] x,
                                                        input logic [7:0] q);
        logic signed [RW-1:0] xe;
        logic signed [RW-1:0] bias;
        xe   = {x[BIN-1], x};
        bias = '0;
        if (q != 8'd0)
            bias = {{(RW-1){1'b0}}, 1'b1} << (q - 8'd1);
        return (xe + bias) >>> q;
    endfunction

    function automatic logic is_sat(input logic signed [RW-1:0] r);
        return (r > MAXV) || (r < MINV);
    endfunction

    function automatic logic [BOUT-1:0] sat_comp(input logic signed [RW-1:0] r);
        if (r > MAXV)
            return {1'b0, {(BOUT-1){1'b1}}};
        else if (r < MINV)
            return {1'b1, {(BOUT-1){1'b0}}};
        else
            return r[BOUT-1:0];
    endfunction

    logic                      w_adv1;
    logic                      w_adv2;
    logic                      w_xfer;
    logic [7:0]                w_q;
    logic signed [RW-1:0]      w_rnd [2*N];
    logic [N*2*BOUT-1:0]       w_sdat;
    logic [N-1:0]              w_ovf_set;

    logic                      r_vld_p1;
    logic signed [RW-1:0]      r_dat_p1 [2*N];
    logic                      r_vld_p2;
    logic [N*2*BOUT-1:0]       r_dat_p2;
    logic [CW-1:0]             r_cnt_p2;
    logic [N-1:0]              r_ovf;

    assign w_adv2        = !r_vld_p2 || m_axis_tready;
    assign w_adv1        = !r_vld_p1 || w_adv2;
    assign w_xfer        = r_vld_p2 && m_axis_tready;
    assign s_axis_tready = w_adv1;
    assign w_q           = (qout > 8'(QMAX)) ? 8'(QMAX) : qout;

    always_comb begin
        for (int k = 0; k < 2*N; k++)
            w_rnd[k] = '0;
        for (int k = 0; k < N; k++) begin
            w_rnd[2*k]   = round_comp(s_axis_tdata[k*2*BIN +: BIN], w_q);
            w_rnd[2*k+1] = round_comp(s_axis_tdata[k*2*BIN+BIN +: BIN], w_q);
        end
    end

    // S1: rounded components, shift fixed at acceptance
    always_ff @(posedge aclk) begin
        if (s_axis_tvalid && w_adv1)
            r_dat_p1 <= w_rnd;
    end

    always_comb begin
        w_sdat    = '0;
        w_ovf_set = '0;
        for (int k = 0; k < N; k++) begin
            w_sdat[k*2*BOUT +: BOUT]      = sat_comp(r_dat_p1[2*k]);
            w_sdat[k*2*BOUT+BOUT +: BOUT] = sat_comp(r_dat_p1[2*k+1]);
            w_ovf_set[k] = is_sat(r_dat_p1[2*k]) || is_sat(r_dat_p1[2*k+1]);
        end
    end

    // S2: saturated output register, frame counter and sticky flags
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_dat_p2 <= '0;
            r_cnt_p2 <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_adv1)
                r_vld_p1 <= s_axis_tvalid;
            if (w_adv2) begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1)
                    r_dat_p2 <= w_sdat;
            end
            if (w_xfer)
                r_cnt_p2 <= (r_cnt_p2 == CW'(FRAME-1)) ? '0 : r_cnt_p2 + 1'b1;
            // A new saturation event outranks a simultaneous clear.
            r_ovf <= (ovf_clr ? '0 : r_ovf) | ((r_vld_p1 && w_adv2) ? w_ovf_set : '0);
        end
    end

    assign m_axis_tvalid = r_vld_p2;
    assign m_axis_tdata  = r_dat_p2;
    assign m_axis_tlast  = r_vld_p2 && (r_cnt_p2 == CW'(FRAME-1));
    assign ovf           = r_ovf;

endmodule

// File: tb/tb_axis_pfb_qout_v2.sv
// Directed bench for axis_pfb_qout_v2: rounding, saturation, sticky flags,
// backpressure, frame tlast and asynchronous reset.
module tb_axis_pfb_qout_v2;

    localparam int N    = 16;
    localparam int BIN  = 24;
    localparam int BOUT = 16;
    localparam int FR   = 4;

    logic                  aclk = 1'b0;
    logic                  aresetn;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [N*2*BIN-1:0]    s_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [N*2*BOUT-1:0]   m_axis_tdata;
    logic                  m_axis_tlast;
    logic [7:0]            qout;
    logic                  ovf_clr;
    logic [N-1:0]          ovf;

    int nchk = 0;
    int nerr = 0;
    int outn = 0;
    int vseq = 0;

    axis_pfb_qout_v2 #(.N(N), .BIN(BIN), .BOUT(BOUT), .FRAME(FR)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .qout(qout), .ovf_clr(ovf_clr), .ovf(ovf)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    function automatic logic [N*2*BIN-1:0] mk(input int ch, input logic [23:0] vi, input logic [23:0] vq);
        logic [N*2*BIN-1:0] d;
        d = '0;
        d[ch*2*BIN +: BIN]     = vi;
        d[ch*2*BIN+BIN +: BIN] = vq;
        return d;
    endfunction

    function automatic logic [15:0] out_i(input int ch);
        return m_axis_tdata[ch*2*BOUT +: BOUT];
    endfunction

    function automatic logic [15:0] out_q(input int ch);
        return m_axis_tdata[ch*2*BOUT+BOUT +: BOUT];
    endfunction

    task automatic send_beat(input logic [N*2*BIN-1:0] d);
        int k;
        k = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        #1;
        while (!s_axis_tready && k < 10) begin
            step();
            k++;
        end
        chk("send_ready", k < 10, 1'b1);
        step();
        s_axis_tvalid = 1'b0;
    endtask

    // Waits for the next output beat, checks it, then lets it transfer (m_axis_tready held high).
    task automatic wait_out(input string tag, input int ch, input logic [15:0] ei,
                            input logic [15:0] eq, input int lat);
        int waited;
        waited = 0;
        #1;
        while (!m_axis_tvalid && waited < 8) begin
            step();
            waited++;
        end
        chk({tag, "_vld"}, m_axis_tvalid, 1'b1);
        if (lat >= 0)
            chk({tag, "_lat"}, waited, lat);
        chk({tag, "_i"}, out_i(ch), ei);
        chk({tag, "_q"}, out_q(ch), eq);
        chk({tag, "_last"}, m_axis_tlast, (outn % FR) == FR - 1);
        step();
        outn++;
    endtask

    // mode 0: m_axis_tready low for the first 5 cycles; mode 1: random stalls
    task automatic run_stream(input string tag, input int nb, input int mode);
        int sent, rcv, cyc, base;
        logic stalled, hold_last;
        logic [N*2*BOUT-1:0] hold_d;
        sent = 0; rcv = 0; cyc = 0; base = vseq;
        stalled = 1'b0; hold_last = 1'b0; hold_d = '0;
        while ((sent < nb || rcv < nb) && cyc < 300) begin
            m_axis_tready = (mode == 0) ? (cyc >= 5) : 1'($urandom_range(0, 1));
            s_axis_tvalid = (sent < nb);
            s_axis_tdata  = mk(0, 24'((base + sent + 1) << 8), 24'h0);
            #1;
            if (mode == 0 && cyc == 4) begin
                chk({tag, "_accepted"}, sent, 2);
                chk({tag, "_sready"}, s_axis_tready, 1'b0);
            end
            if (stalled) begin
                chk({tag, "_hold_vld"}, m_axis_tvalid, 1'b1);
                chk({tag, "_hold_data"}, m_axis_tdata === hold_d, 1'b1);
                chk({tag, "_hold_last"}, m_axis_tlast, hold_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                chk({tag, "_data"}, out_i(0), 16'(base + rcv + 1));
                chk({tag, "_last"}, m_axis_tlast, (outn % FR) == FR - 1);
                rcv++;
                outn++;
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            hold_d    = m_axis_tdata;
            hold_last = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready)
                sent++;
            step();
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        chk({tag, "_count"}, rcv, nb);
        vseq += nb;
    endtask

    initial begin
        aresetn       = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        qout          = 8'd8;
        ovf_clr       = 1'b0;
        #1 aresetn = 1'b0;
        #1;
        chk("rst_mvalid", m_axis_tvalid, 1'b0);
        chk("rst_mlast", m_axis_tlast, 1'b0);
        chk("rst_mdata", m_axis_tdata === '0, 1'b1);
        chk("rst_ovf", ovf, 16'h0000);
        chk("rst_sready", s_axis_tready, 1'b1);
        step();
        step();
        aresetn = 1'b1;
        step();

        // Round half up at q=8
        qout = 8'd8;
        send_beat(mk(0, 24'h123480, 24'h000040));
        wait_out("round", 0, 16'h1235, 16'h0000, 1);
        chk("round_ovf", ovf, 16'h0000);

        // Saturation both directions at q=0
        qout = 8'd0;
        send_beat(mk(3, 24'h010000, 24'hFF0000));
        wait_out("sat", 3, 16'h7FFF, 16'h8000, 1);
        chk("sat_ovf", ovf, 16'h0008);

        // Clear coincident with a new saturation on another channel
        send_beat(mk(5, 24'h7FFFFF, 24'h000000));
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        #1;
        chk("setwins_ovf", ovf, 16'h0020);
        wait_out("setwins", 5, 16'h7FFF, 16'h0000, 0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        #1;
        chk("clr_ovf", ovf, 16'h0000);

        // Rounding overflow into saturation; qout above BIN-BOUT clamps to 8
        qout = 8'd8;
        send_beat(mk(0, 24'h7FFF80, 24'h000000));
        wait_out("rndsat", 0, 16'h7FFF, 16'h0000, 1);
        chk("rndsat_ovf", ovf, 16'h0001);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        qout = 8'd20;
        send_beat(mk(0, 24'h7FFF80, 24'h000000));
        wait_out("q20", 0, 16'h7FFF, 16'h0000, 1);
        chk("q20_ovf", ovf, 16'h0001);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;

        // Most negative input lands exactly on the minimum without saturating
        qout = 8'd8;
        send_beat(mk(0, 24'h800000, 24'hFFFF80));
        wait_out("negmin", 0, 16'h8000, 16'h0000, 1);
        chk("negmin_ovf", ovf, 16'h0000);

        // Shift is captured at acceptance; later qout change must not matter
        qout = 8'd4;
        send_beat(mk(0, 24'h000018, 24'hFFFFE8));
        qout = 8'd0;
        wait_out("qsample", 0, 16'h0002, 16'hFFFF, 1);

        // Backpressure: 5 stalled cycles then drain
        qout = 8'd8;
        run_stream("bp", 6, 0);

        // Asynchronous reset with two beats held in the pipeline
        qout = 8'd0;
        send_beat(mk(2, 24'h7FFFFF, 24'h000000));
        wait_out("presat", 2, 16'h7FFF, 16'h0000, 1);
        qout = 8'd8;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = mk(0, 24'h000500, 24'h0);
        step();
        step();
        s_axis_tvalid = 1'b0;
        #1;
        chk("inflight_vld", m_axis_tvalid, 1'b1);
        chk("inflight_ovf", ovf, 16'h0004);
        aresetn = 1'b0;
        #1;
        chk("arst_mvalid", m_axis_tvalid, 1'b0);
        chk("arst_ovf", ovf, 16'h0000);
        chk("arst_mlast", m_axis_tlast, 1'b0);
        chk("arst_sready", s_axis_tready, 1'b1);
        step();
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        outn = 0;
        #1;
        chk("post_rst_vld", m_axis_tvalid, 1'b0);

        // Frame tlast on beats 4 and 8 with random stalls
        run_stream("frame", 9, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
